load_store_unit: RTL and testbench

- Sits between the core's execute/memory stage and the byte-addressed, word-wide data memory.
- The memory exposes a single word port with a word-aligned combinational read and a write on the rising clock edge.
- This block converts RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word accesses. It uses a read-modify-write sequence for sub-word stores and extracts/extends sub-word loads.
- It stalls the core through a ready/done handshake.

---
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: turns LB/LH/LW/LBU/LHU/SB/SH/SW into aligned word accesses.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned halfword/word requests with err).
module load_store_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RDATA_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                done_q;
  logic                err_q;
  logic [ADDR_W-1:0]   mem_a_q;
  logic [DATA_W-1:0]   mem_wd_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [1:0]          lo_q;
  logic [HALF_W-1:0]   wdata_q;

  logic                legal_c;
  logic                bad_c;
  logic [7:0]          byte_c;
  logic [HALF_W-1:0]   half_c;
  logic [DATA_W-1:0]   load_val_c;
  logic [DATA_W-1:0]   merge_c;

  // funct3 legality for the incoming request
  always_comb begin
    legal_c = 1'b0;
    if (req_we) begin
      legal_c = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
    end else begin
      legal_c = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_c;
  assign misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign bad_c = !legal_c || misalign_c;
`else
  assign bad_c = !legal_c;
`endif

  // Lane extraction for loads and lane replacement for sub-word store merges
  always_comb begin
    byte_c     = 8'h00;
    half_c     = lo_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    load_val_c = mem_RD;
    merge_c    = mem_RD;
    case (lo_q)
      2'd0:    byte_c = mem_RD[7:0];
      2'd1:    byte_c = mem_RD[15:8];
      2'd2:    byte_c = mem_RD[23:16];
      default: byte_c = mem_RD[31:24];
    endcase
    case (f3_q)
      3'b000:  load_val_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_val_c = {24'h00_0000, byte_c};
      3'b001:  load_val_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_val_c = {16'h0000, half_c};
      default: load_val_c = mem_RD;
    endcase
    if (f3_q[1:0] == 2'b00) begin
      case (lo_q)
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end else if (lo_q[1]) begin
      merge_c[31:16] = wdata_q;
    end else begin
      merge_c[15:0] = wdata_q;
    end
  end

  // Control FSM with registered handshake and memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
      rdata_q     <= RDATA_RST;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            lo_q        <= req_addr[1:0];
            wdata_q     <= req_wdata[HALF_W-1:0];
            req_ready_q <= 1'b0;
            if (bad_c) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
              mem_a_q <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && (req_funct3[1:0] == 2'b10)) begin
                mem_wd_q <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (we_q && (f3_q[1:0] != 2'b10)) begin
            state_q  <= MERGE_WR;
            mem_wd_q <= merge_c;
          end else begin
            state_q <= RESP;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            if (!we_q) begin
              rdata_q <= load_val_c;
            end
          end
        end
        MERGE_WR: begin
          state_q <= RESP;
          done_q  <= 1'b1;
          err_q   <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          err_q       <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Write strobe is a pure state decode so it drops the instant rst rises
  assign mem_WE    = (state_q == MERGE_WR) ||
                     ((state_q == ACCESS) && we_q && (f3_q[1:0] == 2'b10));
  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_A     = mem_a_q;
  assign mem_WD    = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: word memory plus a byte-level reference model.
module tb_load_store_unit;

  localparam logic [31:0] RST_VAL = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  load_store_unit #(.ADDR_W(32), .RDATA_RST(RST_VAL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // 1 KiB data memory; backdoor port used only while the unit is idle or in reset
  logic [31:0] mem [0:255];
  logic        bk_we = 1'b0;
  logic [7:0]  bk_idx = 8'h0;
  logic [31:0] bk_data = 32'h0;
  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[9:2]] <= mem_WD;
    else if (bk_we) mem[bk_idx] <= bk_data;
  end

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_rdata;

  int          o_lat;
  logic        o_err;
  logic [7:0]  o_wemask;
  logic [31:0] o_wd;
  logic [31:0] o_a;
  logic [31:0] o_rdata;
  logic        o_ready_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_mem[wa+3], ref_mem[wa+2], ref_mem[wa+1], ref_mem[wa]};
  endfunction

  task automatic poke(input int widx, input logic [31:0] d);
    bk_we = 1'b1;
    bk_idx = 8'(widx);
    bk_data = d;
    for (int b = 0; b < 4; b++) ref_mem[widx*4+b] = d[8*b +: 8];
    @(posedge clk);
    #1;
    bk_we = 1'b0;
  endtask

  // Issue one request from an idle cycle and record what the unit does until done
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    o_lat = 0; o_err = 1'b0; o_wemask = 8'h00; o_wd = 32'h0; o_a = 32'h0;
    o_rdata = 32'h0; o_ready_low = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (mem_WE) begin
        o_wemask[cyc] = 1'b1;
        o_wd = mem_WD;
      end
      if (cyc == 1) o_a = mem_A;
      if (req_ready) o_ready_low = 1'b0;
      if (done) begin
        o_lat = cyc; o_err = err; o_rdata = rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: expected behaviour derived from byte-addressed memory semantics
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int size, a, ea, wa, exp_lat;
    logic legal, misal, bad;
    logic [7:0] exp_mask;
    logic [31:0] v, exp_wd;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    a = int'(addr[9:0]);
    misal = legal && ((a % size) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = !legal || misal;
`else
    bad = !legal;
`endif
    ea = a - (a % size);
    wa = a - (a % 4);
    exp_wd = 32'h0; exp_mask = 8'h00; exp_lat = 1;
    if (!bad && !we) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[ea+i]) << (8*i));
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rdata = v;
      exp_lat = 2;
    end else if (!bad) begin
      for (int i = 0; i < size; i++) ref_mem[ea+i] = wd[8*i +: 8];
      exp_wd = ref_word(wa);
      exp_lat = (size == 4) ? 2 : 3;
      exp_mask = 8'(1 << (exp_lat - 1));
    end
    do_op(we, f3, addr, wd);
    check({tag, "_lat"}, 32'(o_lat), 32'(exp_lat));
    check({tag, "_err"}, {31'b0, o_err}, {31'b0, bad});
    check({tag, "_we"}, 32'(o_wemask), 32'(exp_mask));
    if (exp_mask != 8'h00) check({tag, "_wd"}, o_wd, exp_wd);
    if (!bad) check({tag, "_addr"}, o_a, {addr[31:2], 2'b00});
    check({tag, "_busy"}, {31'b0, o_ready_low}, 32'd1);
    check({tag, "_rdata"}, o_rdata, exp_rdata);
    check({tag, "_mem"}, mem[wa/4], ref_word(wa));
    check({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_we", {31'b0, mem_WE}, 32'd0);
    check("rst_a", mem_A, 32'h0);
    check("rst_wd", mem_WD, 32'h0);
    check("rst_rdata", rdata, RST_VAL);
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    exp_rdata = RST_VAL;
    @(negedge clk);
    rst = 1'b0;

    poke(32'h100 / 4, 32'h8877_6655);
    run_op("lb", 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_val", o_rdata, 32'hFFFF_FF88);
    run_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0);
    check("lbu_val", o_rdata, 32'h0000_0088);

    poke(32'h100 / 4, 32'h1122_3344);
    run_op("sb", 1'b1, 3'b000, 32'h101, 32'hAAAA_AAAA);
    check("sb_wd", o_wd, 32'h1122_AA44);
    check("sb_wecyc", 32'(o_wemask), 32'h4);
    run_op("lw_after_sb", 1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_after_sb_val", o_rdata, 32'h1122_AA44);

    poke(32'h100 / 4, 32'h1122_3344);
    run_op("sh", 1'b1, 3'b001, 32'h102, 32'h0000_BEEF);
    check("sh_wd", o_wd, 32'hBEEF_3344);
    run_op("lh", 1'b0, 3'b001, 32'h102, 32'h0);
    check("lh_val", o_rdata, 32'hFFFF_BEEF);
    run_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0);
    check("lhu_val", o_rdata, 32'h0000_BEEF);

    run_op("sw", 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF);
    run_op("lw_b2b", 1'b0, 3'b010, 32'h104, 32'h0);
    check("lw_b2b_val", o_rdata, 32'hDEAD_BEEF);

    run_op("ill_ld", 1'b0, 3'b011, 32'h100, 32'h0);
    check("ill_ld_err", {31'b0, o_err}, 32'd1);
    check("ill_ld_rdata", o_rdata, 32'hDEAD_BEEF);
    run_op("ill_st", 1'b1, 3'b100, 32'h108, 32'h1234_5678);
    run_op("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_trap", {31'b0, o_err}, 32'd1);
`else
    check("lw_mis_word", o_rdata, 32'hBEEF_3344);
`endif
    run_op("sh_mis", 1'b1, 3'b001, 32'h10B, 32'h0000_7E57);

    // Reset during the merge-write cycle must abandon the write
    poke(32'h200 / 4, 32'h5566_7788);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h201; req_wdata = 32'h0000_00A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rmw_we_merge", {31'b0, mem_WE}, 32'd1);
    rst = 1'b1;
    #1;
    check("rmw_rst_we", {31'b0, mem_WE}, 32'd0);
    check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
    check("rmw_rst_rdata", rdata, RST_VAL);
    exp_rdata = RST_VAL;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rmw_mem_kept", mem[32'h200 / 4], 32'h5566_7788);

    for (int n = 0; n < 200; n++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
